// File: rtl/ccm_pkg.sv
// Shared constants, types and the round/clamp helper for the colour-correction matrix.
package ccm_pkg;

  localparam int COEF_W      = 12;
  localparam int FRAC_BITS   = 8;
  localparam int ROUND_CONST = 128;
  localparam int COEF_ONE    = 256;
  localparam int N_COEF      = 9;
  localparam int PIX_W       = 8;
  localparam int PROD_W      = PIX_W + 1 + COEF_W;
  localparam int SUM_W       = PROD_W + 2;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef coef_t [N_COEF-1:0]       bank_t;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } pix_t;

  localparam logic [3:0] CCM_M00 = 4'd0;
  localparam logic [3:0] CCM_M01 = 4'd1;
  localparam logic [3:0] CCM_M02 = 4'd2;
  localparam logic [3:0] CCM_M10 = 4'd3;
  localparam logic [3:0] CCM_M11 = 4'd4;
  localparam logic [3:0] CCM_M12 = 4'd5;
  localparam logic [3:0] CCM_M20 = 4'd6;
  localparam logic [3:0] CCM_M21 = 4'd7;
  localparam logic [3:0] CCM_M22 = 4'd8;

  localparam coef_t C_ONE  = coef_t'(COEF_ONE);
  localparam coef_t C_ZERO = coef_t'(0);
  localparam bank_t CCM_IDENTITY = {C_ONE, C_ZERO, C_ZERO,
                                    C_ZERO, C_ONE, C_ZERO,
                                    C_ZERO, C_ZERO, C_ONE};

  // Round half up with an arithmetic shift, then saturate to 0..255.
  function automatic logic [PIX_W-1:0] round_clamp(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] r;
    r = (s + SUM_W'(ROUND_CONST)) >>> FRAC_BITS;
    if (r[SUM_W-1])
      return '0;
    else if (r > SUM_W'(255))
      return '1;
    else
      return r[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/ccm_if.sv
// RGB pixel bus shared between the CCM top level and its per-channel MAC rows.
interface ccm_if;
  import ccm_pkg::*;

  pix_t pix;

  modport master (output pix);
  modport slave  (input  pix);
endinterface

// File: rtl/ccm_mac_row.sv
// One output channel: three products (S1), row sum (S2), round and clamp (S3).
// Latency 3 clocks, one pixel per clock, no backpressure.
module ccm_mac_row
  import ccm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  ccm_if.slave             pix_in,
  input  coef_t            m_r,
  input  coef_t            m_g,
  input  coef_t            m_b,
  output logic [PIX_W-1:0] res
);

  logic signed [PIX_W:0]    x_r, x_g, x_b;
  logic signed [PROD_W-1:0] p_r, p_g, p_b;
  logic signed [SUM_W-1:0]  sum;

  assign x_r = {1'b0, pix_in.pix.r};
  assign x_g = {1'b0, pix_in.pix.g};
  assign x_b = {1'b0, pix_in.pix.b};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_r <= '0;
      p_g <= '0;
      p_b <= '0;
      sum <= '0;
      res <= '0;
    end else begin
      p_r <= PROD_W'(x_r) * PROD_W'(m_r);
      p_g <= PROD_W'(x_g) * PROD_W'(m_g);
      p_b <= PROD_W'(x_b) * PROD_W'(m_b);
      sum <= SUM_W'(p_r) + SUM_W'(p_g) + SUM_W'(p_b);
      res <= round_clamp(sum);
    end
  end

endmodule

// File: rtl/ccm_top.sv
// Colour-correction matrix: shadow/active coefficient banks swapped on vsync rise, 3 MAC rows.
// Latency 3 clocks for data and syncs, one pixel per clock, no backpressure.
module ccm_top
  import ccm_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_vsync,
  input  logic             in_hsync,
  input  logic             in_den,
  input  logic [PIX_W-1:0] in_data_R,
  input  logic [PIX_W-1:0] in_data_G,
  input  logic [PIX_W-1:0] in_data_B,
  input  logic             coef_wr,
  input  logic [3:0]       coef_addr,
  input  coef_t            coef_data,
  input  logic             ccm_bypass,
  output logic             out_vsync,
  output logic             out_hsync,
  output logic             out_den,
  output logic [PIX_W-1:0] out_data_R,
  output logic [PIX_W-1:0] out_data_G,
  output logic [PIX_W-1:0] out_data_B
);

  bank_t            shadow;
  bank_t            active;
  logic             byp_act;
  logic             vs_prev;
  logic             vs_rise;
  logic [2:0]       vs_d, hs_d, den_d, byp_d;
  pix_t             pix_d [0:2];
  logic [PIX_W-1:0] res_r, res_g, res_b;

  ccm_if pix_bus ();
  assign pix_bus.pix = {in_data_R, in_data_G, in_data_B};

  assign vs_rise = in_vsync & ~vs_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= CCM_IDENTITY;
    end else if (coef_wr && (coef_addr <= CCM_M22)) begin
      shadow[coef_addr] <= coef_data;
    end
  end

  // Non-blocking load takes the pre-write shadow when a write coincides with the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active  <= CCM_IDENTITY;
      byp_act <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      vs_prev <= in_vsync;
      if (vs_rise) begin
        active  <= shadow;
        byp_act <= ccm_bypass;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_d  <= '0;
      hs_d  <= '0;
      den_d <= '0;
      byp_d <= '0;
      for (int i = 0; i < 3; i++) pix_d[i] <= '0;
    end else begin
      vs_d  <= {vs_d[1:0], in_vsync};
      hs_d  <= {hs_d[1:0], in_hsync};
      den_d <= {den_d[1:0], in_den};
      byp_d <= {byp_d[1:0], byp_act};
      pix_d[0] <= pix_bus.pix;
      pix_d[1] <= pix_d[0];
      pix_d[2] <= pix_d[1];
    end
  end

  ccm_mac_row u_row_r (
    .clk    (clk),
    .reset  (reset),
    .pix_in (pix_bus),
    .m_r    (active[CCM_M00]),
    .m_g    (active[CCM_M01]),
    .m_b    (active[CCM_M02]),
    .res    (res_r)
  );

  ccm_mac_row u_row_g (
    .clk    (clk),
    .reset  (reset),
    .pix_in (pix_bus),
    .m_r    (active[CCM_M10]),
    .m_g    (active[CCM_M11]),
    .m_b    (active[CCM_M12]),
    .res    (res_g)
  );

  ccm_mac_row u_row_b (
    .clk    (clk),
    .reset  (reset),
    .pix_in (pix_bus),
    .m_r    (active[CCM_M20]),
    .m_g    (active[CCM_M21]),
    .m_b    (active[CCM_M22]),
    .res    (res_b)
  );

  assign out_vsync = vs_d[2];
  assign out_hsync = hs_d[2];
  assign out_den   = den_d[2];

  always_comb begin
    out_data_R = '0;
    out_data_G = '0;
    out_data_B = '0;
    if (den_d[2]) begin
      if (byp_d[2]) begin
        out_data_R = pix_d[2].r;
        out_data_G = pix_d[2].g;
        out_data_B = pix_d[2].b;
      end else begin
        out_data_R = res_r;
        out_data_G = res_g;
        out_data_B = res_b;
      end
    end
  end

endmodule

// File: tb/tb_ccm_top.sv
// Directed bench for ccm_top: vector tables per matrix plus frame-boundary and reset sequences.
module tb_ccm_top;
  import ccm_pkg::*;

  typedef struct {
    logic       den;
    logic       hs;
    logic [7:0] r, g, b;
    logic [7:0] er, eg, eb;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        vsync, hsync, den;
  logic        coef_wr;
  logic [3:0]  coef_addr;
  logic [11:0] coef_data;
  logic        ccm_bypass;
  logic        out_vsync, out_hsync, out_den;
  logic [7:0]  out_data_R, out_data_G, out_data_B;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t tv [0:16];

  ccm_if src ();

  ccm_top dut (
    .clk        (clk),
    .reset      (reset),
    .in_vsync   (vsync),
    .in_hsync   (hsync),
    .in_den     (den),
    .in_data_R  (src.pix.r),
    .in_data_G  (src.pix.g),
    .in_data_B  (src.pix.b),
    .coef_wr    (coef_wr),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .ccm_bypass (ccm_bypass),
    .out_vsync  (out_vsync),
    .out_hsync  (out_hsync),
    .out_den    (out_den),
    .out_data_R (out_data_R),
    .out_data_G (out_data_G),
    .out_data_B (out_data_B)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] out_pix();
    return 32'({out_data_R, out_data_G, out_data_B});
  endfunction

  task automatic wr_coef(input logic [3:0] a, input int d);
    @(negedge clk);
    coef_wr   = 1'b1;
    coef_addr = a;
    coef_data = 12'(d);
    @(negedge clk);
    coef_wr   = 1'b0;
  endtask

  // One-cycle vsync pulse, optionally with a coefficient write in the edge cycle.
  task automatic pulse_vsync(input logic with_wr, input logic [3:0] a, input int d);
    @(negedge clk);
    vsync = 1'b1;
    if (with_wr) begin
      coef_wr   = 1'b1;
      coef_addr = a;
      coef_data = 12'(d);
    end
    @(negedge clk);
    vsync   = 1'b0;
    coef_wr = 1'b0;
    @(negedge clk);
    chk("vsync before latency", 32'(out_vsync), 32'd0);
    @(negedge clk);
    chk("vsync at latency", 32'(out_vsync), 32'd1);
    @(negedge clk);
    chk("vsync after pulse", 32'(out_vsync), 32'd0);
  endtask

  task automatic check_pix(input string name, input logic [7:0] r, g, b, er, eg, eb);
    @(negedge clk);
    den     = 1'b1;
    src.pix = {r, g, b};
    @(negedge clk);
    den = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk(name, out_pix(), 32'({er, eg, eb}));
  endtask

  // Streams tv[lo..hi] back to back; each record is checked 3 clocks after it is driven.
  task automatic run_seg(input string name, input int lo, input int hi);
    for (int i = lo; i <= hi + 3; i++) begin
      @(negedge clk);
      if (i - 3 >= lo) begin
        chk($sformatf("%s[%0d] data", name, i - 3), out_pix(),
            32'({tv[i-3].er, tv[i-3].eg, tv[i-3].eb}));
        chk($sformatf("%s[%0d] den/hs", name, i - 3), 32'({out_den, out_hsync}),
            32'({tv[i-3].den, tv[i-3].hs}));
      end
      if (i <= hi) begin
        den     = tv[i].den;
        hsync   = tv[i].hs;
        src.pix = {tv[i].r, tv[i].g, tv[i].b};
      end else begin
        den     = 1'b0;
        hsync   = 1'b0;
        src.pix = '0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // identity
    tv[0]  = '{1'b1, 1'b0, 8'd200, 8'd100, 8'd50,  8'd200, 8'd100, 8'd50};
    tv[1]  = '{1'b1, 1'b1, 8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0};
    tv[2]  = '{1'b1, 1'b0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    tv[3]  = '{1'b0, 1'b0, 8'd9,   8'd9,   8'd9,   8'd0,   8'd0,   8'd0};
    tv[4]  = '{1'b1, 1'b0, 8'd1,   8'd2,   8'd3,   8'd1,   8'd2,   8'd3};
    // row0 = {384,-64,-64}
    tv[5]  = '{1'b1, 1'b0, 8'd200, 8'd100, 8'd50,  8'd255, 8'd100, 8'd50};
    tv[6]  = '{1'b1, 1'b0, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
    tv[7]  = '{1'b1, 1'b0, 8'd10,  8'd200, 8'd200, 8'd0,   8'd200, 8'd200};
    tv[8]  = '{1'b1, 1'b0, 8'd128, 8'd0,   8'd0,   8'd192, 8'd0,   8'd0};
    // bypass latched over a non-identity matrix
    tv[9]  = '{1'b1, 1'b1, 8'd200, 8'd100, 8'd50,  8'd200, 8'd100, 8'd50};
    tv[10] = '{1'b1, 1'b0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    tv[11] = '{1'b0, 1'b1, 8'd5,   8'd5,   8'd5,   8'd0,   8'd0,   8'd0};
    tv[12] = '{1'b1, 1'b0, 8'd0,   8'd200, 8'd0,   8'd0,   8'd200, 8'd0};
    // row0 = {128,0,0}, row1 = {0,-256,0}, row2 identity
    tv[13] = '{1'b1, 1'b0, 8'd1,   8'd5,   8'd7,   8'd1,   8'd0,   8'd7};
    tv[14] = '{1'b1, 1'b0, 8'd3,   8'd0,   8'd9,   8'd2,   8'd0,   8'd9};
    tv[15] = '{1'b1, 1'b0, 8'd255, 8'd255, 8'd0,   8'd128, 8'd0,   8'd0};
    tv[16] = '{1'b1, 1'b0, 8'd200, 8'd100, 8'd50,  8'd100, 8'd0,   8'd50};

    reset      = 1'b1;
    vsync      = 1'b1;
    hsync      = 1'b1;
    den        = 1'b1;
    src.pix    = {8'd200, 8'd100, 8'd50};
    coef_wr    = 1'b0;
    coef_addr  = '0;
    coef_data  = '0;
    ccm_bypass = 1'b0;

    repeat (4) @(negedge clk);
    chk("reset data", out_pix(), 32'd0);
    chk("reset syncs", 32'({out_vsync, out_hsync, out_den}), 32'd0);
    vsync = 1'b0;
    hsync = 1'b0;
    den   = 1'b0;
    reset = 1'b0;

    run_seg("identity", 0, 4);

    wr_coef(CCM_M00, 384);
    wr_coef(CCM_M01, -64);
    wr_coef(CCM_M02, -64);
    pulse_vsync(1'b0, 4'd0, 0);
    run_seg("matrix A", 5, 8);

    // mid-frame write stays in shadow; edge-cycle write lands one frame later
    wr_coef(CCM_M00, 256);
    check_pix("mid-frame write held", 8'd200, 8'd100, 8'd50, 8'd255, 8'd100, 8'd50);
    pulse_vsync(1'b1, CCM_M11, 512);
    check_pix("new frame, edge write pending", 8'd200, 8'd100, 8'd50, 8'd163, 8'd100, 8'd50);
    pulse_vsync(1'b0, 4'd0, 0);
    check_pix("edge write applied", 8'd200, 8'd100, 8'd50, 8'd163, 8'd200, 8'd50);

    ccm_bypass = 1'b1;
    pulse_vsync(1'b0, 4'd0, 0);
    ccm_bypass = 1'b0;
    run_seg("bypass", 9, 12);

    wr_coef(CCM_M00, 128);
    wr_coef(CCM_M01, 0);
    wr_coef(CCM_M02, 0);
    wr_coef(CCM_M11, -256);
    wr_coef(4'd12, 2047);
    pulse_vsync(1'b0, 4'd0, 0);
    run_seg("matrix B", 13, 16);

    // asynchronous reset in the middle of a line
    @(negedge clk);
    den     = 1'b1;
    src.pix = {8'd200, 8'd100, 8'd50};
    repeat (3) @(negedge clk);
    chk("pre-reset stream", out_pix(), 32'({8'd100, 8'd0, 8'd50}));
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async reset data", out_pix(), 32'd0);
    chk("async reset den", 32'(out_den), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("refill empty data", out_pix(), 32'd0);
    chk("refill empty den", 32'(out_den), 32'd0);
    @(negedge clk);
    chk("refill identity data", out_pix(), 32'({8'd200, 8'd100, 8'd50}));
    chk("refill den", 32'(out_den), 32'd1);
    den = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
